noc_link_credit_tx: RTL



---
 rtl/noc_link_pkg.sv | 14 +
 rtl/noc_credit_counter.sv | 35 +++
 rtl/noc_link_credit_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/noc_link_pkg.sv
// noc_link_pkg: link state, flit layout and credit sizing shared by the link transmitter and receiver
package noc_link_pkg;
   localparam int LINK_FLIT_WIDTH = 32;
   localparam int LINK_DEST_WIDTH = 6;
   typedef enum logic {HEAD, BODY} link_pkt_state_t;
   typedef struct packed {
      logic [LINK_FLIT_WIDTH-1:0] data;
      logic [LINK_DEST_WIDTH-1:0] dest;
      logic                       is_tail;
   } link_flit_t;
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: saturating up/down credit counter, loads DEPTH on reset, sticky overflow flag
module noc_credit_counter import noc_link_pkg::*; #(
   parameter int DEPTH = 1,
   parameter int WIDTH = credit_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o,
   output logic             ovf_o
);
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, full, empty;
   // a lone increment at full saturates and raises the flag; a lone decrement at zero holds
   always_comb begin
      full    = count_q == WIDTH'(DEPTH);
      empty   = count_q == '0;
      count_d = (dec_i && !inc_i && !empty) ? count_q - WIDTH'(1) :
                (inc_i && !dec_i && !full)  ? count_q + WIDTH'(1) : count_q;
      ovf_d   = ovf_q || (inc_i && !dec_i && full);
   end
   // counter and flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= WIDTH'(DEPTH);
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end
   assign count_o = count_q;
   assign ovf_o   = ovf_q;
endmodule

// File: rtl/noc_link_credit_tx.sv
// noc_link_credit_tx: credit-based wormhole flit transmitter; NOC_LINK_TX_STATS_EN builds the flit/packet counters
module noc_link_credit_tx import noc_link_pkg::*; #(
   parameter int FLIT_WIDTH   = 32,
   parameter int DEST_WIDTH   = 6,
   parameter int CREDIT_DEPTH = 1,
   parameter int CREDIT_WIDTH = credit_width(CREDIT_DEPTH),
   parameter int STAT_WIDTH   = 16
) (
   input  logic                    clk_noc,
   input  logic                    rst_noc_sync,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FLIT_WIDTH-1:0]   in_data,
   input  logic [DEST_WIDTH-1:0]   in_dest,
   input  logic                    in_last,
   output logic [FLIT_WIDTH-1:0]   data_out,
   output logic [DEST_WIDTH-1:0]   dest_out,
   output logic                    is_tail_out,
   output logic                    send_out,
   input  logic                    credit_in,
   output logic [CREDIT_WIDTH-1:0] credit_count,
   output logic                    pkt_active,
   output logic                    err_credit_ovf,
   output logic [STAT_WIDTH-1:0]   stat_flits,
   output logic [STAT_WIDTH-1:0]   stat_pkts
);
   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  is_tail;
   } flit_t;
   link_pkt_state_t       state_q, state_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d, dest_sel;
   flit_t                 flit_q, flit_d;
   logic                  send_q, accept;
   noc_credit_counter #(.DEPTH(CREDIT_DEPTH), .WIDTH(CREDIT_WIDTH)) u_credit (
      .clk    (clk_noc),
      .rst    (rst_noc_sync),
      .dec_i  (accept),
      .inc_i  (credit_in),
      .count_o(credit_count),
      .ovf_o  (err_credit_ovf)
   );
   assign in_ready = credit_count != '0;
   // head flits pick up in_dest; body and tail flits reuse the packet's latched destination
   always_comb begin
      accept   = in_valid && in_ready;
      dest_sel = (state_q == HEAD) ? in_dest : dest_q;
      dest_d   = accept ? dest_sel : dest_q;
      state_d  = accept ? (in_last ? HEAD : BODY) : state_q;
      flit_d   = accept ? {in_data, dest_sel, in_last} : flit_q;
   end
   // packet state, latched destination and registered link outputs
   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         state_q <= HEAD;
         dest_q  <= '0;
         flit_q  <= '0;
         send_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         flit_q  <= flit_d;
         send_q  <= accept;
      end
   end
   assign data_out    = flit_q.data;
   assign dest_out    = flit_q.dest;
   assign is_tail_out = flit_q.is_tail;
   assign send_out    = send_q;
   assign pkt_active  = state_q == BODY;
`ifdef NOC_LINK_TX_STATS_EN
   logic [STAT_WIDTH-1:0] flits_q, flits_d, pkts_q, pkts_d;
   // flits and tails sent, wrapping
   always_comb begin
      flits_d = flits_q + STAT_WIDTH'(accept);
      pkts_d  = pkts_q + STAT_WIDTH'(accept && in_last);
   end
   // statistics registers
   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         flits_q <= '0;
         pkts_q  <= '0;
      end else begin
         flits_q <= flits_d;
         pkts_q  <= pkts_d;
      end
   end
   assign stat_flits = flits_q;
   assign stat_pkts  = pkts_q;
`else
   assign stat_flits = '0;
   assign stat_pkts  = '0;
`endif
endmodule
